// File: rtl/puf_challenge_sequencer.sv
// Challenge sequencer for a ring-oscillator PUF: steps through N_BITS challenge
// pairs, times each reset/measure window, and collects one response bit per pair.
module puf_challenge_sequencer #(
    parameter int N_BITS       = 16,
    parameter int RESET_CYCLES = 4,
    parameter int MEAS_CYCLES  = 200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        seed,
    output logic              group_reset,
    output logic [3:0]        cha0,
    output logic [3:0]        cha1,
    input  logic              response_in,
    output logic              busy,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [N_BITS-1:0] resp_data
);

    localparam int          TW        = 20;
    localparam int          KW        = 5;
    localparam logic [TW-1:0] RST_LAST  = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] MEAS_LAST = TW'(MEAS_CYCLES - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_MEAS,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic [KW-1:0]     k_q;
    logic [7:0]        seed_q;
    logic [3:0]        cha0_q, cha1_q;
    logic              group_reset_q;
    logic              busy_q;
    logic              resp_valid_q;
    logic [N_BITS-1:0] resp_data_q;
    logic [N_BITS-1:0] resp_data_d;
    logic [1:0]        sync_q;

    logic              accept;
    logic              sample_wr;
    logic [7:0]        seed_sel;
    logic [3:0]        k_sel;
    logic [3:0]        lo_sel, hi_sel;
    logic [3:0]        cha0_d, cha1_d;

    assign accept    = (state_q == S_IDLE) && start;
    assign sample_wr = (state_q == S_SAMPLE);

    // response_in comes from the free-running oscillator race, so it is retimed
    // through two flops; only sync_q[1] is ever sampled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], response_in};
        end
    end

    // Selects for the bit about to start: k=0 from the live seed on acceptance,
    // otherwise k+1 from the captured seed. Equal selects are pushed apart by one.
    always_comb begin
        seed_sel = seed_q;
        k_sel    = k_q[3:0] + 4'd1;
        if (state_q == S_IDLE) begin
            seed_sel = seed;
            k_sel    = 4'd0;
        end
        lo_sel = seed_sel[3:0] + k_sel;
        hi_sel = seed_sel[7:4] + k_sel;
        cha0_d = lo_sel;
        cha1_d = (hi_sel == lo_sel) ? hi_sel + 4'd1 : hi_sel;
    end

    for (genvar gi = 0; gi < N_BITS; gi++) begin : g_resp_bit
        always_comb begin
            resp_data_d[gi] = resp_data_q[gi];
            if (accept) begin
                resp_data_d[gi] = 1'b0;
            end else if (sample_wr && (k_q == KW'(gi))) begin
                resp_data_d[gi] = sync_q[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_data_q <= '0;
        end else begin
            resp_data_q <= resp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            k_q           <= '0;
            seed_q        <= 8'h00;
            cha0_q        <= 4'h0;
            cha1_q        <= 4'h0;
            group_reset_q <= 1'b1;
            busy_q        <= 1'b0;
            resp_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    group_reset_q <= 1'b1;
                    if (start) begin
                        seed_q  <= seed;
                        k_q     <= '0;
                        timer_q <= '0;
                        cha0_q  <= cha0_d;
                        cha1_q  <= cha1_d;
                        busy_q  <= 1'b1;
                        state_q <= S_RST;
                    end
                end
                S_RST: begin
                    if (timer_q == RST_LAST) begin
                        timer_q       <= '0;
                        group_reset_q <= 1'b0;
                        state_q       <= S_MEAS;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_MEAS: begin
                    if (timer_q == MEAS_LAST) begin
                        timer_q <= '0;
                        state_q <= S_SAMPLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    // Counters stay released for the sample cycle so the race
                    // result cannot be disturbed while it is being captured.
                    group_reset_q <= 1'b1;
                    timer_q       <= '0;
                    if (k_q == K_LAST) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        cha0_q  <= cha0_d;
                        cha1_q  <= cha1_d;
                        state_q <= S_RST;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    group_reset_q <= 1'b1;
                    busy_q        <= 1'b0;
                    resp_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign group_reset = group_reset_q;
    assign cha0        = cha0_q;
    assign cha1        = cha1_q;
    assign busy        = busy_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer: table of seed/response patterns
// plus hand-written reset, ignored-start and simultaneous start/ready sequences.
module tb_puf_challenge_sequencer;

    localparam int NB      = 4;
    localparam int RC      = 2;
    localparam int MC      = 10;
    localparam int BIT_CYC = RC + MC + 1;
    localparam int EXP_LAT = 1 + NB * BIT_CYC;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    seed = 8'h00;
    logic          response_in = 1'b0;
    logic          resp_ready = 1'b0;
    logic          group_reset;
    logic [3:0]    cha0, cha1;
    logic          busy;
    logic          resp_valid;
    logic [NB-1:0] resp_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    puf_challenge_sequencer #(
        .N_BITS      (NB),
        .RESET_CYCLES(RC),
        .MEAS_CYCLES (MC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seed       (seed),
        .group_reset(group_reset),
        .cha0       (cha0),
        .cha1       (cha1),
        .response_in(response_in),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    typedef struct {
        logic [7:0]  seed;
        logic [3:0]  pattern;   // response_in level for bit k, bit 0 first
        logic        inject;    // stray start pulses in RST and DONE
        logic [3:0]  exp_data;
        logic [15:0] exp_cha0;  // nibble k = expected cha0 for bit k
        logic [15:0] exp_cha1;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge n=0 is the acceptance edge; the word must be visible once EXP_LAT
    // edges, counted from and including the acceptance edge, have occurred.
    task automatic run_vec(input vec_t v, input int idx);
        int rise;
        int b;
        int ph;
        rise = -1;
        seed  = v.seed;
        start = 1'b1;
        tick();
        start = 1'b0;
        seed  = 8'h00;
        check($sformatf("v%0d busy_after_accept", idx), 32'(busy), 1);
        for (int n = 0; n < EXP_LAT + 20 && rise < 0; n++) begin
            if (resp_valid) begin
                rise = n;
            end else begin
                b  = n / BIT_CYC;
                ph = n % BIT_CYC;
                if (b < NB) begin
                    if (ph == 0) response_in = v.pattern[b];
                    if (ph == 0) check($sformatf("v%0d b%0d grst_in_rst", idx, b), 32'(group_reset), 1);
                    if (ph == RC) check($sformatf("v%0d b%0d grst_in_meas", idx, b), 32'(group_reset), 0);
                    if (ph == RC + 3) begin
                        check($sformatf("v%0d b%0d cha0", idx, b), 32'(cha0), 32'(v.exp_cha0[4*b +: 4]));
                        check($sformatf("v%0d b%0d cha1", idx, b), 32'(cha1), 32'(v.exp_cha1[4*b +: 4]));
                    end
                    start = v.inject && (b == 0) && (ph == 1);
                    seed  = start ? 8'hFF : 8'h00;
                end
                tick();
            end
        end
        start = 1'b0;
        check($sformatf("v%0d valid_latency", idx), 32'(rise + 1), EXP_LAT);
        check($sformatf("v%0d resp_data", idx), 32'(resp_data), 32'(v.exp_data));
        check($sformatf("v%0d grst_in_done", idx), 32'(group_reset), 1);
        for (int i = 0; i < 3; i++) begin
            start = v.inject && (i == 1);
            seed  = start ? 8'hFF : 8'h00;
            tick();
            start = 1'b0;
            check($sformatf("v%0d hold%0d valid", idx, i), 32'(resp_valid), 1);
            check($sformatf("v%0d hold%0d data", idx, i), 32'(resp_data), 32'(v.exp_data));
        end
        resp_ready = 1'b1;
        start      = v.inject;
        seed       = 8'hFF;
        tick();
        resp_ready = 1'b0;
        start      = 1'b0;
        check($sformatf("v%0d valid_after_hs", idx), 32'(resp_valid), 0);
        check($sformatf("v%0d busy_after_hs", idx), 32'(busy), 0);
        tick();
        check($sformatf("v%0d still_idle", idx), 32'(busy), 0);
        check($sformatf("v%0d grst_in_idle", idx), 32'(group_reset), 1);
    endtask

    initial begin
        int highs;
        vecs[0] = '{8'h31, 4'b1111, 1'b0, 4'b1111, 16'h4321, 16'h6543};
        vecs[1] = '{8'h00, 4'b1101, 1'b0, 4'b1101, 16'h3210, 16'h4321};
        vecs[2] = '{8'hFE, 4'b0010, 1'b0, 4'b0010, 16'h10FE, 16'h210F};
        vecs[3] = '{8'h5A, 4'b0000, 1'b0, 4'b0000, 16'hDCBA, 16'h8765};
        vecs[4] = '{8'h22, 4'b0110, 1'b0, 4'b0110, 16'h5432, 16'h6543};
        vecs[5] = '{8'h31, 4'b1001, 1'b1, 4'b1001, 16'h4321, 16'h6543};

        // Reset held with start asserted: nothing may be accepted.
        reset       = 1'b0;
        start       = 1'b1;
        seed        = 8'hAB;
        response_in = 1'b1;
        repeat (3) tick();
        check("rst busy", 32'(busy), 0);
        check("rst valid", 32'(resp_valid), 0);
        check("rst grst", 32'(group_reset), 1);
        check("rst cha0", 32'(cha0), 0);
        check("rst cha1", 32'(cha1), 0);
        check("rst data", 32'(resp_data), 0);
        start = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        check("idle_no_start busy", 32'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset during MEAS of bit 2 (edges 28..37 after acceptance).
        seed  = 8'h31;
        start = 1'b1;
        tick();
        start       = 1'b0;
        response_in = 1'b1;
        for (int n = 0; n < 2 * BIT_CYC + RC + 3; n++) tick();
        check("midrst pre grst", 32'(group_reset), 0);
        check("midrst pre cha0", 32'(cha0), 3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst busy", 32'(busy), 0);
        check("midrst grst", 32'(group_reset), 1);
        check("midrst data", 32'(resp_data), 0);
        check("midrst cha0", 32'(cha0), 0);
        check("midrst cha1", 32'(cha1), 0);
        highs = 0;
        for (int n = 0; n < EXP_LAT + 10; n++) begin
            if (resp_valid) highs++;
            tick();
        end
        check("midrst no_valid", 32'(highs), 0);
        check("midrst still_idle", 32'(busy), 0);

        run_vec(vecs[1], 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
